board_redraw_engine: RTL

Incremental board renderer for the chess project. Continuously scans the 64-square board memory through the view read port. Redraws a square only when its piece code or cursor state differs from a per-square shadow copy. For each redraw it streams 900 pixels (one 30x30 square, sprite composited over the square shade) into the single-pixel plot port of `vga_adapter`.

---
 rtl/chess_pkg.sv | 43 ++++
 rtl/square_pixel_counter.sv | 32 +++
 rtl/board_redraw_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// Shared chess-project definitions: piece codes, board/screen geometry and the
// redraw engine's FSM states.
package chess_pkg;

    localparam int SQ_PX         = 30;
    localparam int SPRITE_WORDS  = SQ_PX * SQ_PX;
    localparam int BOARD_DIM     = 8;
    localparam int BOARD_SQUARES = BOARD_DIM * BOARD_DIM;
    localparam int BOARD_PX      = BOARD_DIM * SQ_PX;
    localparam int SCREEN_W      = 320;
    localparam int SCREEN_H      = 240;

    typedef enum logic [3:0] {
        P_EMPTY    = 4'd0,
        P_B_PAWN   = 4'd1,
        P_B_KNIGHT = 4'd2,
        P_B_BISHOP = 4'd3,
        P_B_ROOK   = 4'd4,
        P_B_QUEEN  = 4'd5,
        P_B_KING   = 4'd6,
        P_W_PAWN   = 4'd7,
        P_W_KNIGHT = 4'd8,
        P_W_BISHOP = 4'd9,
        P_W_ROOK   = 4'd10,
        P_W_QUEEN  = 4'd11,
        P_W_KING   = 4'd12
    } piece_e;

    localparam logic [3:0] PIECE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        S_ADDR,
        S_READ,
        S_DRAW,
        S_FLUSH
    } state_e;

    // Codes 0 and 13..15 have no sprite and render as a bare square.
    function automatic logic piece_has_sprite(input logic [3:0] piece);
        return (piece >= 4'd1) && (piece <= 4'd12);
    endfunction

endpackage

// File: rtl/square_pixel_counter.sv
// Column/row raster counter over one square, column fastest, wrapping to (0,0)
// after the last pixel.
module square_pixel_counter
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    output logic [4:0] col,
    output logic [4:0] row,
    output logic       last
);

    localparam logic [4:0] MAX = 5'(SQ_PX - 1);

    assign last = (col == MAX) && (row == MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == MAX) begin
                col <= '0;
                row <= (row == MAX) ? '0 : row + 5'd1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

endmodule

// File: rtl/board_redraw_engine.sv
// Incremental board renderer: scans the 64 squares, compares each against a
// shadow copy and streams 900 pixels for every square that changed.
module board_redraw_engine
    import chess_pkg::*;
#(
    parameter int BOARD_X0 = 40,
    parameter int SQ_PX    = 30
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        can_render,
    input  logic        redraw_all,
    input  logic [2:0]  box_x,
    input  logic [2:0]  box_y,
    output logic [2:0]  view_x,
    output logic [2:0]  view_y,
    input  logic [3:0]  data_out_view,
    output logic [13:0] sprite_addr,
    input  logic [1:0]  sprite_data,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        colour,
    output logic        plot,
    output logic        busy,
    output logic        scan_wrap
);

    state_e      state;
    logic [5:0]  sq;
    logic [4:0]  shadow [BOARD_SQUARES];
    logic [3:0]  draw_piece;
    logic        draw_cur;
    logic [2:0]  draw_bx;
    logic [2:0]  draw_by;
    logic [13:0] draw_base;
    logic [4:0]  col;
    logic [4:0]  row;
    logic        last;
    logic        vld_p1;
    logic [4:0]  col_p1;
    logic [4:0]  row_p1;
    logic        is_cur;
    logic        dirty;
    logic        advance;

    function automatic logic [13:0] sprite_base(input logic [3:0] piece);
        if (!piece_has_sprite(piece))
            return '0;
        return 14'(piece - 4'd1) * 14'(SPRITE_WORDS);
    endfunction

    // Cursor frame beats the sprite; an opaque sprite texel beats the square shade.
    function automatic logic pix_colour(input logic [3:0] piece, input logic cur,
                                        input logic [2:0] bx, input logic [2:0] by,
                                        input logic [4:0] c, input logic [4:0] r,
                                        input logic [1:0] spr);
        logic shade;
        logic edge_px;
        shade   = ~(bx[0] ^ by[0]);
        edge_px = (c == 5'd0) || (r == 5'd0) || (c == 5'(SQ_PX - 1)) || (r == 5'(SQ_PX - 1));
        if (cur && edge_px)
            return ~shade;
        if (piece_has_sprite(piece) && spr[1])
            return spr[0];
        return shade;
    endfunction

    assign view_x  = sq[2:0];
    assign view_y  = sq[5:3];
    assign is_cur  = (sq[2:0] == box_x) && (sq[5:3] == box_y);
    assign dirty   = {data_out_view, is_cur} != shadow[sq];
    assign advance = ((state == S_READ) && !dirty) || (state == S_FLUSH);

    assign sprite_addr = ((state == S_DRAW) && piece_has_sprite(draw_piece))
                       ? draw_base + 14'(row) * 14'(SQ_PX) + 14'(col) : '0;

    square_pixel_counter u_pix_cnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (state == S_DRAW),
        .col    (col),
        .row    (row),
        .last   (last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_ADDR;
            sq        <= '0;
            busy      <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            scan_wrap <= advance && (sq == 6'd63);
            if (advance)
                sq <= sq + 6'd1;
            case (state)
                S_ADDR: if (can_render) state <= S_READ;
                S_READ: begin
                    if (dirty) begin
                        state <= S_DRAW;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_ADDR;
                    end
                end
                S_DRAW: if (last) state <= S_FLUSH;
                S_FLUSH: begin
                    state <= S_ADDR;
                    busy  <= 1'b0;
                end
                default: state <= S_ADDR;
            endcase
        end
    end

    // A redraw_all in the same cycle as a shadow update wins, so that entry stays invalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BOARD_SQUARES; i++)
                shadow[i] <= {PIECE_INVALID, 1'b0};
        end else if (redraw_all) begin
            for (int i = 0; i < BOARD_SQUARES; i++)
                shadow[i] <= {PIECE_INVALID, 1'b0};
        end else if ((state == S_READ) && dirty) begin
            shadow[sq] <= {data_out_view, is_cur};
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_READ) && dirty) begin
            draw_piece <= data_out_view;
            draw_cur   <= is_cur;
            draw_bx    <= sq[2:0];
            draw_by    <= sq[5:3];
            draw_base  <= sprite_base(data_out_view);
        end
    end

    // p1: sprite ROM word arrives; pixel coordinates delayed to meet it
    always_ff @(posedge clk) begin
        col_p1 <= col;
        row_p1 <= row;
    end

    // Output stage: registered plot strobe with coordinates and colour
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= 1'b0;
        end else begin
            vld_p1 <= (state == S_DRAW);
            plot   <= vld_p1;
            if (vld_p1) begin
                x      <= 9'(BOARD_X0) + 9'(draw_bx) * 9'(SQ_PX) + 9'(col_p1);
                y      <= 8'(draw_by) * 8'(SQ_PX) + 8'(row_p1);
                colour <= pix_colour(draw_piece, draw_cur, draw_bx, draw_by,
                                     col_p1, row_p1, sprite_data);
            end
        end
    end

endmodule
